fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding/hazard controller for the 5-stage MIPS pipeline. Drives the selects of the two 32-bit 3:1 ALU-operand forwarding muxes.
//  Select encoding: 2'b00 = register file, 2'b01 = WB result, 2'b10 = MEM ALU result.
//  Keeps a shadow pipeline (EX/MEM/WB) of destination/control info. Detects load-use hazards and freezes on data-memory busy.
//  Sits beside the ID/EX register; its outputs feed the EX-stage forwarding muxes and the PC/IF-ID/ID-EX enables.
// PARAMETERS
//  RA_W    5   register-address width
//  CNT_W   16  width of statistics counters (FWD_STATS_EN only)
// PORTS
//  Clk          in   1     clock, all state on rising edge
//  Rst          in   1     synchronous reset, active-high
//  id_valid     in   1     ID holds a real instruction
//  id_rs        in   RA_W  ID source reg A
//  id_rt        in   RA_W  ID source reg B
//  id_uses_rs   in   1     ID instruction reads rs
//  id_uses_rt   in   1     ID instruction reads rt
//  id_rd        in   RA_W  ID destination reg (already rt/rd-selected)
//  id_regwrite  in   1     ID instruction writes id_rd
//  id_memread   in   1     ID instruction is a load
//  flush        in   1     branch/jump taken: kill instruction in ID
//  mem_busy     in   1     data memory not done: freeze whole pipe
//  fwd_a_sel    out  2     select for operand-A mux (registered)
//  fwd_b_sel    out  2     select for operand-B mux (registered)
//  stall        out  1     hold PC and IF/ID (combinational)
//  bubble       out  1     zero ID/EX control this edge (combinational)
//  freeze       out  1     hold all pipeline registers (= state HOLD or mem_busy)
//  stall_count  out  CNT_W load-use stall cycles
//  fwd_count    out  CNT_W EX operands forwarded
// BEHAVIOUR
//  Reset: all shadow valid bits 0, fwd_a_sel = fwd_b_sel = 2'b00, state RUN, counters 0. stall/bubble/freeze are 0 while Rst is high.
//  Shadow stages: EX, MEM, WB. Each stage holds {valid, regwrite, memread, rd}; EX also holds rs/rt and their use bits.
//  "Writes r" = valid && regwrite && rd != 0. Register $0 never forwards and never stalls.
//  Load-use hazard (combinational, in RUN): EX.valid && EX.memread && EX.rd != 0 && id_valid && ((id_uses_rs && id_rs == EX.rd) || (id_uses_rt && id_rt == EX.rd)).
//  When the hazard is true: stall = 1, bubble = 1.
//  flush = 1: bubble = 1, stall = 0. flush wins over the load-use hazard in the same cycle.
//  Advance edge (state RUN, mem_busy = 0): WB <= MEM, MEM <= EX.
//    EX <= ID fields, or an invalid entry if bubble.
//  fwd_a_sel/fwd_b_sel are registered on the same advance edge, from next-EX rs/rt:
//    - 2'b10 if current EX writes rs/rt (it becomes MEM)
//    - else 2'b01 if current MEM writes it (it becomes WB)
//    - else 2'b00
//    - a bubble or an unused operand gives 2'b00
//  Selects are therefore valid for the full cycle the instruction occupies EX. The latest producer has priority.
//  FSM: RUN -> HOLD when mem_busy = 1. In HOLD the shadow pipe, selects and counters are frozen and freeze = 1.
//    HOLD -> RUN on the first cycle with mem_busy = 0; that cycle is a normal RUN cycle with no advance.
//    The advance resumes on the following edge. Hazard and flush evaluation is suppressed (0) in HOLD.
//  Rst mid-operation clears everything on that edge regardless of state or mem_busy.
// CONFIGURATION
//  FWD_STATS_EN defined: on each advance edge, stall_count increments when stall = 1.
//    fwd_count increments by the number of selects set to nonzero (0..2). Both counters saturate at all-ones.
//  FWD_STATS_EN undefined: no counter registers; stall_count and fwd_count are tied to 0.
// TESTING
//  1. ADD $3 then SUB $4,$3,$5 back-to-back -> for SUB in EX, fwd_a_sel = 2'b10 and fwd_b_sel = 2'b00.
//  2. ADD $3, NOP, OR $6,$0,$3 -> fwd_b_sel = 2'b01. Writer to $0 followed by a reader of $0 -> selects 2'b00.
//  3. LW $2, then ADD $7,$2,$2 -> one cycle of stall = bubble = 1, then ADD in EX with both selects 2'b01;
//     with FWD_STATS_EN, stall_count = 1 and fwd_count = 2.
//  4. ADD $8 in MEM and ADDI $8 in EX, consumer of $8 next -> 2'b10 (youngest producer wins).
//  5. Load-use hazard and flush in the same cycle -> stall = 0, bubble = 1, no duplicate fetch.
//     mem_busy high for 3 cycles -> freeze = 1 for those 3 cycles and selects unchanged.
//  6. Assert Rst during HOLD with a pending hazard -> next cycle selects 2'b00, stall = 0, counters 0, state RUN.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller that sits beside the ID/EX register of a 5-stage MIPS pipeline.
// Define FWD_STATS_EN to build the stall_count and fwd_count statistics counters; otherwise both outputs are tied to 0.
module fwd_hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             mem_busy,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             bubble,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] fwd_count
);

    typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic [RA_W-1:0] rd;
    } stage_t;

    typedef struct packed {
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            uses_rs;
        logic            uses_rt;
    } src_t;

    state_t     state_q, state_d;
    stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    src_t       ex_src_q, ex_src_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       hazard, advance;

    function automatic logic writes(input stage_t s, input logic [RA_W-1:0] r);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
    endfunction

    // The youngest producer (the one now in EX, moving to MEM) takes priority.
    function automatic logic [1:0] fwd_pick(input logic use_op, input logic [RA_W-1:0] r,
                                            input stage_t ex_s, input stage_t mem_s);
        if (!use_op)            return 2'b00;
        if (writes(ex_s, r))    return 2'b10;
        if (writes(mem_s, r))   return 2'b01;
        return 2'b00;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:  if (mem_busy)  state_d = S_HOLD;
            S_HOLD: if (!mem_busy) state_d = S_RUN;
            default:               state_d = S_RUN;
        endcase
    end

    assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                    ((id_uses_rs && (id_rs == ex_q.rd)) || (id_uses_rt && (id_rt == ex_q.rd)));

    always_comb begin
        stall   = 1'b0;
        bubble  = 1'b0;
        freeze  = 1'b0;
        advance = 1'b0;
        if (!Rst) begin
            freeze = (state_q == S_HOLD) || mem_busy;
            if (state_q == S_RUN) begin
                advance = !mem_busy;
                if (flush) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ex_d     = ex_q;
        ex_src_d = ex_src_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        if (advance) begin
            wb_d           = mem_q;
            mem_d          = ex_q;
            ex_d.valid     = id_valid && !bubble;
            ex_d.regwrite  = id_regwrite;
            ex_d.memread   = id_memread;
            ex_d.rd        = id_rd;
            ex_src_d       = '{rs: id_rs, rt: id_rt, uses_rs: id_uses_rs, uses_rt: id_uses_rt};
            fwd_a_d = fwd_pick(id_valid && !bubble && id_uses_rs, id_rs, ex_q, mem_q);
            fwd_b_d = fwd_pick(id_valid && !bubble && id_uses_rt, id_rt, ex_q, mem_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ex_q     <= '0;
            ex_src_q <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            fwd_a_q  <= 2'b00;
            fwd_b_q  <= 2'b00;
        end else begin
            ex_q     <= ex_d;
            ex_src_q <= ex_src_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

    // WB and the EX source fields mirror the real pipeline but nothing downstream reads them.
    logic unused_shadow;
    assign unused_shadow = ^{wb_q, mem_q.memread, ex_src_q};

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
    logic [1:0]       fwd_inc;
    logic [CNT_W:0]   fwd_sum;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        fwd_inc     = {1'b0, (fwd_a_d != 2'b00)} + {1'b0, (fwd_b_d != 2'b00)};
        fwd_sum     = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_inc};
        if (advance) begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            fwd_cnt_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;
`else
    assign stall_count = '0;
    assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding selects, load-use stall, flush, freeze and reset.
module tb_fwd_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic [RA_W-1:0]  id_rs, id_rt, id_rd;
    logic             flush, mem_busy;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             stall, bubble, freeze;
    logic [CNT_W-1:0] stall_count, fwd_count;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .mem_busy(mem_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .bubble(bubble), .freeze(freeze),
        .stall_count(stall_count), .fwd_count(fwd_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                          input logic urt, input int rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = RA_W'(rs);
        id_rt       = RA_W'(rt);
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_rd       = RA_W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        idle();
        flush    = 1'b0;
        mem_busy = 1'b0;
        tick();
        Rst = 1'b0;
    endtask

    int exp_stall_cnt, exp_fwd_cnt;

    initial begin
        Rst = 1'b1;
        idle();
        flush    = 1'b0;
        mem_busy = 1'b1;
        tick();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bubble", 32'(bubble), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_sel_a", 32'(fwd_a_sel), 32'd0);
        check("rst_sel_b", 32'(fwd_b_sel), 32'd0);
        check("rst_stall_cnt", 32'(stall_count), 32'd0);
        check("rst_fwd_cnt", 32'(fwd_count), 32'd0);
        mem_busy = 1'b0;
        Rst      = 1'b0;

        // ADD $3,$1,$2 ; SUB $4,$3,$5
        set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
        set_id(1, 3, 5, 1, 1, 4, 1, 0); tick();
        check("t1_sel_a", 32'(fwd_a_sel), 32'd2);
        check("t1_sel_b", 32'(fwd_b_sel), 32'd0);
`ifdef FWD_STATS_EN
        exp_fwd_cnt = 1;
`else
        exp_fwd_cnt = 0;
`endif
        check("t1_fwd_cnt", 32'(fwd_count), 32'(exp_fwd_cnt));

        // ADD $3 ; NOP ; OR $6,$0,$3
        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
        idle(); tick();
        set_id(1, 0, 3, 1, 1, 6, 1, 0); tick();
        check("t2_sel_a", 32'(fwd_a_sel), 32'd0);
        check("t2_sel_b", 32'(fwd_b_sel), 32'd1);

        // writer of $0 then reader of $0
        do_reset();
        set_id(1, 1, 2, 1, 1, 0, 1, 0); tick();
        set_id(1, 0, 0, 1, 1, 9, 1, 0); tick();
        check("t2_r0_sel_a", 32'(fwd_a_sel), 32'd0);
        check("t2_r0_sel_b", 32'(fwd_b_sel), 32'd0);

        // LW $2 ; ADD $7,$2,$2
        do_reset();
        set_id(1, 1, 0, 1, 0, 2, 1, 1); tick();
        set_id(1, 2, 2, 1, 1, 7, 1, 0); #1;
        check("t3_stall", 32'(stall), 32'd1);
        check("t3_bubble", 32'(bubble), 32'd1);
        tick();
        check("t3_bub_sel_a", 32'(fwd_a_sel), 32'd0);
        check("t3_stall_after", 32'(stall), 32'd0);
        tick();
        check("t3_sel_a", 32'(fwd_a_sel), 32'd1);
        check("t3_sel_b", 32'(fwd_b_sel), 32'd1);
`ifdef FWD_STATS_EN
        exp_stall_cnt = 1;
        exp_fwd_cnt   = 2;
`else
        exp_stall_cnt = 0;
        exp_fwd_cnt   = 0;
`endif
        check("t3_stall_cnt", 32'(stall_count), 32'(exp_stall_cnt));
        check("t3_fwd_cnt", 32'(fwd_count), 32'(exp_fwd_cnt));

        // ADD $8 ; ADDI $8 ; consumer of $8 ; unused-operand follower
        do_reset();
        set_id(1, 1, 2, 1, 1, 8, 1, 0); tick();
        set_id(1, 1, 0, 1, 0, 8, 1, 0); tick();
        set_id(1, 8, 8, 1, 1, 10, 1, 0); tick();
        check("t4_sel_a", 32'(fwd_a_sel), 32'd2);
        check("t4_sel_b", 32'(fwd_b_sel), 32'd2);
        set_id(1, 8, 8, 1, 0, 12, 1, 0); tick();
        check("t4_mem_sel_a", 32'(fwd_a_sel), 32'd1);
        check("t4_unused_sel_b", 32'(fwd_b_sel), 32'd0);

        // load-use hazard coinciding with flush, then a 3-cycle mem_busy
        do_reset();
        set_id(1, 1, 0, 1, 0, 2, 1, 1); tick();
        set_id(1, 2, 0, 1, 0, 11, 1, 0);
        flush = 1'b1; #1;
        check("t5_flush_stall", 32'(stall), 32'd0);
        check("t5_flush_bubble", 32'(bubble), 32'd1);
        tick();
        flush = 1'b0;
        check("t5_flush_sel_a", 32'(fwd_a_sel), 32'd0);
        tick();
        check("t5_pre_sel_a", 32'(fwd_a_sel), 32'd1);
        set_id(1, 11, 0, 1, 0, 13, 1, 0);
        mem_busy = 1'b1; #1;
        check("t5_freeze_c1", 32'(freeze), 32'd1);
        tick();
        check("t5_freeze_c2", 32'(freeze), 32'd1);
        check("t5_sel_c2", 32'(fwd_a_sel), 32'd1);
        tick();
        check("t5_freeze_c3", 32'(freeze), 32'd1);
        check("t5_sel_c3", 32'(fwd_a_sel), 32'd1);
        tick();
        mem_busy = 1'b0; #1;
        check("t5_freeze_hold_exit", 32'(freeze), 32'd1);
        check("t5_sel_hold_exit", 32'(fwd_a_sel), 32'd1);
        tick();
        check("t5_freeze_run", 32'(freeze), 32'd0);
        check("t5_sel_no_adv", 32'(fwd_a_sel), 32'd1);
        tick();
        check("t5_sel_resume", 32'(fwd_a_sel), 32'd2);

        // reset during HOLD with a pending load-use hazard
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 0); tick();
        set_id(1, 5, 0, 1, 0, 2, 1, 1); tick();
        check("t6_pre_sel_a", 32'(fwd_a_sel), 32'd2);
        set_id(1, 2, 0, 1, 0, 7, 1, 0);
        mem_busy = 1'b1; #1;
        check("t6_run_stall", 32'(stall), 32'd1);
        tick();
        check("t6_hold_stall", 32'(stall), 32'd0);
        check("t6_hold_freeze", 32'(freeze), 32'd1);
        Rst = 1'b1; #1;
        check("t6_rst_freeze", 32'(freeze), 32'd0);
        tick();
        Rst      = 1'b0;
        mem_busy = 1'b0; #1;
        check("t6_sel_a", 32'(fwd_a_sel), 32'd0);
        check("t6_sel_b", 32'(fwd_b_sel), 32'd0);
        check("t6_stall", 32'(stall), 32'd0);
        check("t6_freeze", 32'(freeze), 32'd0);
        check("t6_stall_cnt", 32'(stall_count), 32'd0);
        check("t6_fwd_cnt", 32'(fwd_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
